// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule helpers: S-box, Rcon, RotWord/SubWord and FSM types.
// Consumed by inv_key_sched (optional INV_KEY_SCHED_DIRECT_LOAD_EN build) and key_step.
package aes_pkg;

    localparam int AES_NR = 10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_EMIT   = 2'd2
    } ksState_e;

    typedef enum logic {
        DIR_FWD = 1'b0,
        DIR_INV = 1'b1
    } stepDir_e;

    // Entry 0 occupies the top byte, so entry x sits at bit offset 8*(255-x).
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox_f(input logic [7:0] x);
        logic [10:0] idx;
        idx = {~x, 3'b000};
        return SBOX_TBL[idx +: 8];
    endfunction

    function automatic logic [31:0] rcon_f(input logic [3:0] rnd);
        logic [31:0] rc;
        case (rnd)
            4'd1:    rc = 32'h01000000;
            4'd2:    rc = 32'h02000000;
            4'd3:    rc = 32'h04000000;
            4'd4:    rc = 32'h08000000;
            4'd5:    rc = 32'h10000000;
            4'd6:    rc = 32'h20000000;
            4'd7:    rc = 32'h40000000;
            4'd8:    rc = 32'h80000000;
            4'd9:    rc = 32'h1b000000;
            4'd10:   rc = 32'h36000000;
            default: rc = 32'h00000000;
        endcase
        return rc;
    endfunction

    function automatic logic [31:0] rot_word_f(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [31:0] sub_word_f(input logic [31:0] w);
        return {sbox_f(w[31:24]), sbox_f(w[23:16]), sbox_f(w[15:8]), sbox_f(w[7:0])};
    endfunction

endpackage

// File: rtl/inv_key_sched_if.sv
// Key-load and round-key stream bundle for inv_key_sched.
// key_is_last exists only when INV_KEY_SCHED_DIRECT_LOAD_EN is defined.
interface inv_key_sched_if;

    logic         key_valid;
    logic         key_ready;
    logic [127:0] key_in;
`ifdef INV_KEY_SCHED_DIRECT_LOAD_EN
    logic         key_is_last;
`endif
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk_out;
    logic [3:0]   rk_round;
    logic         rk_last;

    modport slave (
        input  key_valid,
        output key_ready,
        input  key_in,
`ifdef INV_KEY_SCHED_DIRECT_LOAD_EN
        input  key_is_last,
`endif
        output rk_valid,
        input  rk_ready,
        output rk_out,
        output rk_round,
        output rk_last
    );

    modport master (
        output key_valid,
        input  key_ready,
        output key_in,
`ifdef INV_KEY_SCHED_DIRECT_LOAD_EN
        output key_is_last,
`endif
        input  rk_valid,
        output rk_ready,
        input  rk_out,
        input  rk_round,
        input  rk_last
    );

endinterface

// File: rtl/inv_key_sched_key_step.sv
// One AES-128 key-schedule step, forward (K[r-1] -> K[r]) or inverse (K[r] -> K[r-1]).
// Both directions share a single SubWord (four S-boxes) through an input mux.
module key_step
    import aes_pkg::*;
(
    input  stepDir_e     dir,
    input  logic [3:0]   rnd,
    input  logic [127:0] keyIn,
    output logic [127:0] keyOut
);

    logic [31:0] w0S, w1S, w2S, w3S;
    logic [31:0] subInS, tempS;
    logic [31:0] n0S, n1S, n2S;

    // Select the SubWord source by direction, then combine the words.
    always_comb begin
        w0S = keyIn[127:96];
        w1S = keyIn[95:64];
        w2S = keyIn[63:32];
        w3S = keyIn[31:0];
        n0S = 32'h00000000;
        n1S = 32'h00000000;
        n2S = 32'h00000000;
        // The inverse step needs the recovered previous w3, which is w3 ^ w2.
        if (dir == DIR_INV) begin
            subInS = w3S ^ w2S;
        end else begin
            subInS = w3S;
        end
        tempS = sub_word_f(rot_word_f(subInS)) ^ rcon_f(rnd);
        if (dir == DIR_INV) begin
            keyOut = {w0S ^ tempS, w1S ^ w0S, w2S ^ w1S, w3S ^ w2S};
        end else begin
            n0S    = w0S ^ tempS;
            n1S    = w1S ^ n0S;
            n2S    = w2S ^ n1S;
            keyOut = {n0S, n1S, n2S, w3S ^ n2S};
        end
    end

endmodule

// File: rtl/inv_key_sched.sv
// Reverse-order AES-128 round-key generator: expands forward to K10, then streams K10..K0.
// INV_KEY_SCHED_DIRECT_LOAD_EN adds key_is_last to load K10 directly and skip expansion.
module inv_key_sched
    import aes_pkg::*;
#(
    parameter bit IDLE_ZERO = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    inv_key_sched_if.slave ksIf
);

    localparam logic [3:0] LAST_RND = 4'(AES_NR);

    ksState_e     stateR, nextStateS;
    logic [127:0] keyR, keyNextS;
    logic [127:0] rkOutR;
    logic [3:0]   cntR, cntNextS;
    logic [3:0]   rndR, rndNextS;
    stepDir_e     stepDirS;
    logic [3:0]   stepRndS;
    logic [127:0] stepOutS;
    logic         keyHsS, rkHsS, directS;

    key_step u_key_step (
        .dir    (stepDirS),
        .rnd    (stepRndS),
        .keyIn  (keyR),
        .keyOut (stepOutS)
    );

    assign keyHsS = (stateR == ST_IDLE) && ksIf.key_valid;
    assign rkHsS  = (stateR == ST_EMIT) && ksIf.rk_ready;
`ifdef INV_KEY_SCHED_DIRECT_LOAD_EN
    assign directS = ksIf.key_is_last;
`else
    assign directS = 1'b0;
`endif

    // Next-state, key-register and counter update decode.
    always_comb begin
        nextStateS = stateR;
        keyNextS   = keyR;
        cntNextS   = cntR;
        rndNextS   = rndR;
        stepDirS   = DIR_FWD;
        stepRndS   = cntR;
        case (stateR)
            ST_IDLE: begin
                if (keyHsS) begin
                    keyNextS = ksIf.key_in;
                    if (directS) begin
                        nextStateS = ST_EMIT;
                        rndNextS   = LAST_RND;
                        cntNextS   = 4'd0;
                    end else begin
                        nextStateS = ST_EXPAND;
                        cntNextS   = 4'd1;
                    end
                end else begin
                    nextStateS = ST_IDLE;
                end
            end
            ST_EXPAND: begin
                keyNextS = stepOutS;
                if (cntR == LAST_RND) begin
                    nextStateS = ST_EMIT;
                    rndNextS   = LAST_RND;
                    cntNextS   = 4'd0;
                end else begin
                    cntNextS = cntR + 4'd1;
                end
            end
            ST_EMIT: begin
                stepDirS = DIR_INV;
                stepRndS = rndR;
                if (rkHsS) begin
                    if (rndR == 4'd0) begin
                        nextStateS = ST_IDLE;
                    end else begin
                        keyNextS = stepOutS;
                        rndNextS = rndR - 4'd1;
                    end
                end else begin
                    nextStateS = ST_EMIT;
                end
            end
            default: begin
                nextStateS = ST_IDLE;
                cntNextS   = 4'd0;
                rndNextS   = 4'd0;
            end
        endcase
    end

    // State, key and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateR <= ST_IDLE;
            keyR   <= '0;
            cntR   <= 4'd0;
            rndR   <= 4'd0;
        end else begin
            stateR <= nextStateS;
            keyR   <= keyNextS;
            cntR   <= cntNextS;
            rndR   <= rndNextS;
        end
    end

    // Output key register: loads whatever key is presented next cycle, else idles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rkOutR <= '0;
        end else if (nextStateS == ST_EMIT) begin
            rkOutR <= keyNextS;
        end else if (IDLE_ZERO) begin
            rkOutR <= '0;
        end else begin
            rkOutR <= rkOutR;
        end
    end

    assign ksIf.key_ready = (stateR == ST_IDLE);
    assign ksIf.rk_valid  = (stateR == ST_EMIT);
    assign ksIf.rk_out    = rkOutR;
    assign ksIf.rk_round  = rndR;
    assign ksIf.rk_last   = (stateR == ST_EMIT) && (rndR == 4'd0);

endmodule

// File: doc/inv_key_sched.md
# inv_key_sched

Reverse-order AES-128 round-key generator for the decryption datapath. It accepts a cipher key, expands it forward to the last round key (K10), then streams round keys K10, K9, … K0 over a valid/ready interface, in the order the inverse cipher's add-round-key stages consume them. It uses one shared S-box and recomputes each key backward, so no key-schedule RAM is needed.

## Interface
- `IDLE_ZERO`, default 1: when 1, `rk_out` reads zero while `rk_valid` is low; when 0, it holds its last value.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `key_valid` in 1: `key_in` is valid.
- `key_ready` out 1: block can accept a key (IDLE only).
- `key_in` in 128: cipher key. `[127:120]` is FIPS-197 byte 0; w0 = `[127:96]`.
- `rk_valid` out 1: `rk_out` holds a round key.
- `rk_ready` in 1: consumer accepts `rk_out`.
- `rk_out` out 128: round key, same byte order as `key_in`.
- `rk_round` out 4: round index of `rk_out` (10 down to 0).
- `rk_last` out 1: high together with `rk_valid` when `rk_round` == 0.

## Operation
- **States:**
  - **IDLE.** `key_ready`=1. A key handshake latches `key_in` into the key register, sets `cnt`=1 and moves to EXPAND.
  - **EXPAND.** Runs one forward step per cycle: w0' = w0 ^ SubWord(RotWord(w3)) ^ Rcon[cnt]; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'. After the `cnt`=10 step, moves to EMIT with `rnd`=10.
  - **EMIT.** `rk_valid`=1, `rk_out` = key register, `rk_round` = `rnd`.
    - On a handshake with `rnd`>0, apply one inverse step: w3'=w3^w2; w2'=w2^w1; w1'=w1^w0; w0'=w0^SubWord(RotWord(w3'))^Rcon[rnd]. Then decrement `rnd`.
    - On a handshake with `rnd`=0, go to IDLE.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36, placed in the top byte of the word.
- One 8-bit S-box function is instantiated 4× (SubWord). Forward and inverse steps share it, muxed on state.
- `key_valid` outside IDLE is ignored; `key_ready`=0.
- `rk_ready` low in EMIT is a stall: `rk_out`, `rk_round` and `rk_last` stay stable and no step is taken.

## Timing
- **Reset values:** state IDLE, `key_ready`=1, `rk_valid`=0, `rk_last`=0, `rk_round`=0, `rk_out`=0, counters 0.
- **Key acceptance:** key handshake at edge T0. EXPAND occupies T1..T10. `rk_valid` rises after edge T10, with K10 presented.
- **Latency:** 10 cycles from key handshake to first `rk_valid`.
- **Throughput:** one key per cycle with `rk_ready` held high. An 11-key burst is followed by `key_ready`=1 in the cycle after the K0 handshake.
- **Minimum spacing:** 22 cycles between key handshakes.
- **Output timing:** all outputs are registered or decoded from registered state; there are no combinational paths from inputs to outputs.
- **Reset mid-operation:** asserting `rst_n` low in any state returns immediately to reset values; a partial stream is abandoned.
- **Simultaneous events:** `rk_ready` and the step occur on the same edge; the next key appears the following cycle. No bubble is inserted.

## Configuration
- **`INV_KEY_SCHED_DIRECT_LOAD_EN` defined:**
  - Adds input `key_is_last` (1 bit), sampled with the key handshake.
  - When it is 1, `key_in` is taken as K10 and the block goes straight to EMIT (`rnd`=10). `rk_valid` rises the cycle after the handshake.
  - When it is 0, behaviour is as above.
- **Macro undefined:** the port is absent and EXPAND is always run.

## Structure
- **Shared package `aes_pkg`:** `sbox_f` (256-entry forward S-box function), `rcon_f(4-bit)`, `rot_word_f`, `sub_word_f`, the state enum and the constant `AES_NR`=10.
- **Sub-module `key_step`:** combinational, with ports `dir` (fwd/inv), `rnd`, and 128-bit in/out. It holds the single SubWord instance; the top level is FSM, counters and registers.

## Test plan
- **Forward expansion, FIPS-197:** key 2b7e151628aed2a6abf7158809cf4f3c, `rk_ready`=1 → first key d014f9a8c9ee2589e13f0cc8b6630ca6 (`rk_round`=10) at latency 10. K1 = a0fafe1788542cb123a339392a6c7605. K0 equals the input key with `rk_last`=1.
- **Random stalls:** random `rk_ready` → identical 11-key sequence; outputs stable while stalled; `key_ready` returns after K0.
- **Back-to-back keys:** two keys back-to-back, with a second `key_valid` held high during EXPAND/EMIT → second key accepted only after the first stream ends; correct streams for both.
- **Reset during operation:** `rst_n` low during EMIT at `rnd`=5 → all outputs at reset values at once; a new key afterwards produces a full correct stream.
- **All-zero key:** all-zero key → K10 b4ef5bcb3e92e21123e951cf6f8f188e.
- **Direct load (with `INV_KEY_SCHED_DIRECT_LOAD_EN`):** load K10 above with `key_is_last`=1 → `rk_valid` the next cycle, ending at K0 = 2b7e…4f3c.
